// File: rtl/mux_arb2_pkg.sv
// Shared encodings for the two-source mux arbiter.
package mux_arb2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SRV_A = 2'd1,
    SRV_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_arb2_pkg

// File: rtl/mux_arb2_mux2_w.sv
// WIDTH-wide 2:1 data mux steered by the arbiter select.
module mux2_w
  import mux_arb2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] y_c_o
);

  // Pure combinational select; the consumer registers the result.
  assign y_c_o = (sel_i == SEL_B) ? d1_i : d0_i;

endmodule : mux2_w

// File: rtl/mux_arb2.sv
// Round-robin two-source arbiter with burst limit, driving a 2:1 mux and
// registering its output into a valid/ready stage.
module mux_arb2
  import mux_arb2_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int unsigned      CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sw_q, sw_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] mux_y;
  logic             load_en;

  // Select comes straight from the state register.
  assign sel     = (state_q == SRV_B) ? SEL_B : SEL_A;
  assign load_en = !y_valid_q || y_ready;

  // sw_q marks the single dead cycle after an owner switch.
  assign gnt_a = (state_q == SRV_A) && req_a && load_en && !sw_q;
  assign gnt_b = (state_q == SRV_B) && req_b && load_en && !sw_q;

  assign y       = y_q;
  assign y_valid = y_valid_q;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .sel_i (sel),
    .d0_i  (a),
    .d1_i  (b),
    .y_c_o (mux_y)
  );

  // Next-state: output stage, burst counter, owner FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sw_d      = 1'b0;
    y_d       = y_q;
    y_valid_d = y_valid_q;

    if (gnt_a || gnt_b) begin
      y_d       = mux_y;
      y_valid_d = 1'b1;
      last_d    = gnt_b ? SEL_B : SEL_A;
      // Saturate so a lone requester keeps ownership indefinitely.
      cnt_d     = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = (last_q == SEL_A) ? SRV_B : SRV_A;
        end else if (req_a) begin
          state_d = SRV_A;
        end else if (req_b) begin
          state_d = SRV_B;
        end
      end
      SRV_A: begin
        if ((gnt_a && (cnt_q == CNT_LAST) && req_b) || (!req_a && req_b)) begin
          state_d = SRV_B;
          sw_d    = 1'b1;
        end else if (!req_a && !req_b) begin
          state_d = IDLE;
        end
      end
      SRV_B: begin
        if ((gnt_b && (cnt_q == CNT_LAST) && req_a) || (!req_b && req_a)) begin
          state_d = SRV_A;
          sw_d    = 1'b1;
        end else if (!req_a && !req_b) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // State and output registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_B;
      sw_q      <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sw_q      <= sw_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

endmodule : mux_arb2

// File: tb/tb_mux_arb2.sv
// Directed self-checking bench for mux_arb2 (WIDTH = 8, MAX_HOLD = 4).
module tb_mux_arb2;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic             clk;
  logic             rst_n;
  logic             req_a, req_b;
  logic [WIDTH-1:0] a, b;
  logic             gnt_a, gnt_b, sel;
  logic [WIDTH-1:0] y;
  logic             y_valid, y_ready;

  int checks = 0;
  int passes = 0;

  mux_arb2 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .a       (a),
    .req_b   (req_b),
    .b       (b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n   = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    a       = '0;
    b       = '0;
    y_ready = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_a   = 1'($urandom);
      req_b   = 1'($urandom);
      a       = WIDTH'($urandom);
      b       = WIDTH'($urandom);
      y_ready = 1'($urandom);
      #1;
      checks++;
      if (y !== 8'h00 || y_valid !== 1'b0 || sel !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0)
        $display("FAIL reset_outputs cyc%0d: y=%h v=%b sel=%b ga=%b gb=%b, want 00 0 0 0 0",
                 i, y, y_valid, sel, gnt_a, gnt_b);
      else passes++;
      tick;
    end
    req_a = 1'b0; req_b = 1'b0; a = '0; b = '0; y_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    req_a = 1'b1; a = 8'hA5; y_ready = 1'b1;
    #1;
    checks++;
    if (gnt_a !== 1'b0) $display("FAIL single_idle_gnt: gnt_a=%b want 0", gnt_a);
    else passes++;
    tick;
    checks++;
    if (gnt_a !== 1'b1 || sel !== 1'b0 || y_valid !== 1'b0)
      $display("FAIL single_first_gnt: gnt_a=%b sel=%b v=%b want 1 0 0", gnt_a, sel, y_valid);
    else passes++;
    tick;
    checks++;
    if (y !== 8'hA5 || y_valid !== 1'b1)
      $display("FAIL single_first_word: y=%h v=%b want a5 1", y, y_valid);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || y !== 8'hA5 || y_valid !== 1'b1)
        $display("FAIL single_stream cyc%0d: ga=%b gb=%b y=%h v=%b want 1 0 a5 1",
                 i, gnt_a, gnt_b, y, y_valid);
      else passes++;
      tick;
    end
  endtask

  task automatic test_tie;
    req_a = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 1'b0) $display("FAIL tie_drop_gnt: gnt_a=%b want 0", gnt_a);
    else passes++;
    tick;
    req_a = 1'b1; req_b = 1'b1; a = 8'h11; b = 8'h22;
    #1;
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || sel !== 1'b0 || y_valid !== 1'b0)
      $display("FAIL tie_idle: ga=%b gb=%b sel=%b v=%b want 0 0 0 0", gnt_a, gnt_b, sel, y_valid);
    else passes++;
    tick;
    checks++;
    if (sel !== 1'b1 || gnt_b !== 1'b1 || gnt_a !== 1'b0)
      $display("FAIL tie_srv_b: sel=%b gb=%b ga=%b want 1 1 0", sel, gnt_b, gnt_a);
    else passes++;
    tick;
    checks++;
    if (y !== 8'h22 || y_valid !== 1'b1)
      $display("FAIL tie_first_word: y=%h v=%b want 22 1", y, y_valid);
    else passes++;
  endtask

  task automatic test_fairness;
    logic             exp_sel, exp_ga, exp_gb, exp_v;
    logic [WIDTH-1:0] exp_y;
    apply_reset;
    req_a = 1'b1; req_b = 1'b1; a = 8'h11; b = 8'h22; y_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      // Grant cycles repeat every 5: four grants then one bubble.
      exp_sel = 1'((k / 5) % 2);
      exp_ga  = (k % 5 != 0) && !exp_sel;
      exp_gb  = (k % 5 != 0) && exp_sel;
      exp_v   = (k >= 2) && ((k - 1) % 5 != 0);
      exp_y   = (((k - 1) / 5) % 2 != 0) ? 8'h22 : 8'h11;
      checks++;
      if (sel !== exp_sel || gnt_a !== exp_ga || gnt_b !== exp_gb || y_valid !== exp_v)
        $display("FAIL fair_ctrl k%0d: sel=%b ga=%b gb=%b v=%b want %b %b %b %b",
                 k, sel, gnt_a, gnt_b, y_valid, exp_sel, exp_ga, exp_gb, exp_v);
      else passes++;
      if (exp_v) begin
        checks++;
        if (y !== exp_y) $display("FAIL fair_data k%0d: y=%h want %h", k, y, exp_y);
        else passes++;
      end
    end
  endtask

  task automatic test_backpressure;
    apply_reset;
    req_a = 1'b1; req_b = 1'b0; a = 8'h40; y_ready = 1'b1;
    tick;
    checks++;
    if (gnt_a !== 1'b1) $display("FAIL bp_start_gnt: gnt_a=%b want 1", gnt_a);
    else passes++;
    tick;
    a = 8'h41;
    checks++;
    if (y !== 8'h40 || y_valid !== 1'b1) $display("FAIL bp_w40: y=%h v=%b want 40 1", y, y_valid);
    else passes++;
    tick;
    a = 8'h42;
    checks++;
    if (y !== 8'h41 || y_valid !== 1'b1) $display("FAIL bp_w41: y=%h v=%b want 41 1", y, y_valid);
    else passes++;
    y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (gnt_a !== 1'b0 || y !== 8'h41 || y_valid !== 1'b1)
        $display("FAIL bp_hold cyc%0d: ga=%b y=%h v=%b want 0 41 1", i, gnt_a, y, y_valid);
      else passes++;
      tick;
    end
    y_ready = 1'b1;
    #1;
    checks++;
    if (gnt_a !== 1'b1) $display("FAIL bp_resume_gnt: gnt_a=%b want 1", gnt_a);
    else passes++;
    tick;
    a = 8'h43;
    checks++;
    if (y !== 8'h42 || y_valid !== 1'b1) $display("FAIL bp_w42: y=%h v=%b want 42 1", y, y_valid);
    else passes++;
    tick;
    a = 8'h44;
    checks++;
    if (y !== 8'h43 || y_valid !== 1'b1) $display("FAIL bp_w43: y=%h v=%b want 43 1", y, y_valid);
    else passes++;
  endtask

  task automatic test_async_reset;
    #3;
    checks++;
    if (y_valid !== 1'b1) $display("FAIL areset_pre: y_valid=%b want 1", y_valid);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y_valid !== 1'b0 || y !== 8'h00 || gnt_a !== 1'b0 || sel !== 1'b0)
      $display("FAIL areset_immediate: v=%b y=%h ga=%b sel=%b want 0 00 0 0",
               y_valid, y, gnt_a, sel);
    else passes++;
    tick;
    rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1; a = 8'h11; b = 8'h22;
    #1;
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0)
      $display("FAIL areset_idle: ga=%b gb=%b want 0 0", gnt_a, gnt_b);
    else passes++;
    tick;
    checks++;
    if (sel !== 1'b0 || gnt_a !== 1'b1 || gnt_b !== 1'b0)
      $display("FAIL areset_a_first: sel=%b ga=%b gb=%b want 0 1 0", sel, gnt_a, gnt_b);
    else passes++;
    tick;
    checks++;
    if (y !== 8'h11 || y_valid !== 1'b1)
      $display("FAIL areset_word: y=%h v=%b want 11 1", y, y_valid);
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0; y_ready = 1'b1;
    test_reset;
    test_single;
    test_tie;
    test_fairness;
    test_backpressure;
    test_async_reset;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_mux_arb2
